// File: rtl/mem_wb_skid_if.sv
// MEM->WB stage bus: valid/ready handshake plus write-back payload.
// HI/LO payload fields exist only when MEM_WB_HILO_EN is defined.
interface mem_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] wd;
  logic              wreg;
  logic [DATA_W-1:0] wdata;
`ifdef MEM_WB_HILO_EN
  logic              whilo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
`endif

`ifdef MEM_WB_HILO_EN
  modport master (output valid, wd, wreg, wdata, whilo, hi, lo, input ready);
  modport slave  (input valid, wd, wreg, wdata, whilo, hi, lo, output ready);
`else
  modport master (output valid, wd, wreg, wdata, input ready);
  modport slave  (input valid, wd, wreg, wdata, output ready);
`endif
endinterface

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a two-entry skid buffer and flush.
// Optional HI/LO write channel enabled by defining MEM_WB_HILO_EN.
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  mem_wb_skid_if.slave        mem,
  mem_wb_skid_if.master       wb,
  output logic [1:0]          wb_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
`ifdef MEM_WB_HILO_EN
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
`endif
  } entry_t;

  entry_t     main_r, skid_r, main_nxt_s, skid_nxt_s, in_s;
  logic       main_valid_r, skid_valid_r, main_valid_nxt_s, skid_valid_nxt_s;
  logic       ready_r;
  logic [1:0] count_r;
  logic       accept_s, pop_s;

  assign accept_s = mem.valid & ready_r;
  assign pop_s    = main_valid_r & wb.ready;

  // Pack the incoming MEM payload into an entry.
  always_comb begin
    in_s       = '0;
    in_s.wd    = mem.wd;
    in_s.wreg  = mem.wreg;
    in_s.wdata = mem.wdata;
`ifdef MEM_WB_HILO_EN
    in_s.whilo = mem.whilo;
    in_s.hi    = mem.hi;
    in_s.lo    = mem.lo;
`endif
  end

  // Next-state selection; vacated entries are cleared so invalid slots read zero.
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      main_nxt_s       = '0;
      skid_nxt_s       = '0;
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!main_valid_r) begin
      if (accept_s) begin
        main_nxt_s       = in_s;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_nxt_s       = '0;
      end
    end else if (pop_s) begin
      if (skid_valid_r) begin
        main_nxt_s       = skid_r;
        skid_nxt_s       = '0;
        skid_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        main_nxt_s       = in_s;
      end else begin
        main_nxt_s       = '0;
        main_valid_nxt_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_nxt_s       = in_s;
      skid_valid_nxt_s = 1'b1;
    end else begin
      main_nxt_s       = main_r;
    end
  end

  // State, ready and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
      count_r      <= 2'd0;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      ready_r      <= ~skid_valid_nxt_s;
      count_r      <= {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
    end
  end

  assign mem.ready = ready_r;
  assign wb.valid  = main_valid_r;
  assign wb.wd     = main_r.wd;
  assign wb.wreg   = main_r.wreg;
  assign wb.wdata  = main_r.wdata;
`ifdef MEM_WB_HILO_EN
  assign wb.whilo  = main_r.whilo;
  assign wb.hi     = main_r.hi;
  assign wb.lo     = main_r.lo;
`endif
  assign wb_count  = count_r;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed-vector bench for mem_wb_skid; define MEM_WB_HILO_EN to exercise HI/LO.
module tb_mem_wb_skid;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] wb_count;
  int         n_vec;
  int         n_err;

  mem_wb_skid_if #(.DATA_W(32), .ADDR_W(5)) mem_bus ();
  mem_wb_skid_if #(.DATA_W(32), .ADDR_W(5)) wb_bus ();

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .mem      (mem_bus),
    .wb       (wb_bus),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_bus.valid = v;
    mem_bus.wd    = wd;
    mem_bus.wreg  = wreg;
    mem_bus.wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic [4:0] wd,
                           input logic wreg, input logic [31:0] wdata,
                           input logic [1:0] cnt, input logic rdy);
    check_eq({tag, ".valid"}, {63'd0, wb_bus.valid}, {63'd0, v});
    check_eq({tag, ".wd"},    {59'd0, wb_bus.wd},    {59'd0, wd});
    check_eq({tag, ".wreg"},  {63'd0, wb_bus.wreg},  {63'd0, wreg});
    check_eq({tag, ".wdata"}, {32'd0, wb_bus.wdata}, {32'd0, wdata});
    check_eq({tag, ".count"}, {62'd0, wb_count},     {62'd0, cnt});
    check_eq({tag, ".ready"}, {63'd0, mem_bus.ready}, {63'd0, rdy});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    wb_bus.ready = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 32'h0000_00AA);
`ifdef MEM_WB_HILO_EN
    mem_bus.whilo = 1'b0;
    mem_bus.hi    = 32'd0;
    mem_bus.lo    = 32'd0;
`endif

    // Reset with a live input: nothing may load.
    tick();
    expect_wb("rst1", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    tick();
    expect_wb("rst2", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    expect_wb("post_rst", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Streaming at full rate.
    wb_bus.ready = 1'b1;
    drive(1'b1, 5'd1, 1'b1, 32'h11);
    tick();
    expect_wb("stream1", 1'b1, 5'd1, 1'b1, 32'h11, 2'd1, 1'b1);
    drive(1'b1, 5'd2, 1'b1, 32'h22);
    tick();
    expect_wb("stream2", 1'b1, 5'd2, 1'b1, 32'h22, 2'd1, 1'b1);
    drive(1'b1, 5'd3, 1'b1, 32'h33);
    tick();
    expect_wb("stream3", 1'b1, 5'd3, 1'b1, 32'h33, 2'd1, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    expect_wb("stream_end", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Backpressure fills the skid; ready drops and main holds.
    wb_bus.ready = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 32'h44);
    tick();
    expect_wb("bp_load4", 1'b1, 5'd4, 1'b1, 32'h44, 2'd1, 1'b1);
    drive(1'b1, 5'd5, 1'b1, 32'h55);
    tick();
    expect_wb("bp_skid5", 1'b1, 5'd4, 1'b1, 32'h44, 2'd2, 1'b0);
    drive(1'b1, 5'd6, 1'b1, 32'h66);
    tick();
    expect_wb("bp_hold", 1'b1, 5'd4, 1'b1, 32'h44, 2'd2, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    wb_bus.ready = 1'b1;
    tick();
    expect_wb("bp_drain5", 1'b1, 5'd5, 1'b1, 32'h55, 2'd1, 1'b1);
    tick();
    expect_wb("bp_empty", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Flush with a full skid and a simultaneous input.
    wb_bus.ready = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 32'h88);
    tick();
    drive(1'b1, 5'd9, 1'b1, 32'h99);
    tick();
    expect_wb("fl_full", 1'b1, 5'd8, 1'b1, 32'h88, 2'd2, 1'b0);
    flush = 1'b1;
    drive(1'b1, 5'd10, 1'b1, 32'hAA);
    tick();
    expect_wb("fl_full_clr", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    // Flush while empty and ready: the accept must be dropped.
    drive(1'b1, 5'd11, 1'b1, 32'hBB);
    tick();
    expect_wb("fl_drop", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    wb_bus.ready = 1'b1;
    tick();
    expect_wb("fl_after", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Bubble zeroing after a lone pop.
    drive(1'b1, 5'd7, 1'b1, 32'h77);
    tick();
    expect_wb("bub_load", 1'b1, 5'd7, 1'b1, 32'h77, 2'd1, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    expect_wb("bub_zero", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Reset mid-stream behaves like flush, even with flush also high.
    wb_bus.ready = 1'b0;
    drive(1'b1, 5'd12, 1'b1, 32'hC0);
    tick();
    drive(1'b1, 5'd13, 1'b1, 32'hD0);
    tick();
    expect_wb("mrst_full", 1'b1, 5'd12, 1'b1, 32'hC0, 2'd2, 1'b0);
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    expect_wb("mrst_clr", 1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);

`ifdef MEM_WB_HILO_EN
    // HI/LO payload held through a stall and cleared after pop.
    wb_bus.ready  = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 32'd0);
    mem_bus.whilo = 1'b1;
    mem_bus.hi    = 32'hDEAD_0000;
    mem_bus.lo    = 32'h0000_BEEF;
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    mem_bus.whilo = 1'b0;
    mem_bus.hi    = 32'd0;
    mem_bus.lo    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      check_eq("hilo_whilo", {63'd0, wb_bus.whilo}, 64'd1);
      check_eq("hilo_hi",    {32'd0, wb_bus.hi},    64'h0000_0000_DEAD_0000);
      check_eq("hilo_lo",    {32'd0, wb_bus.lo},    64'h0000_0000_0000_BEEF);
      tick();
    end
    check_eq("hilo_valid", {63'd0, wb_bus.valid}, 64'd1);
    wb_bus.ready = 1'b1;
    tick();
    check_eq("hilo_clr_whilo", {63'd0, wb_bus.whilo}, 64'd0);
    check_eq("hilo_clr_hi",    {32'd0, wb_bus.hi},    64'd0);
    check_eq("hilo_clr_lo",    {32'd0, wb_bus.lo},    64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
